// File: rtl/pwm_capture_if.sv
// pwm_capture_if: bundle between a PWM pin and the capture block.
//   pwm_in     - asynchronous PWM level from the pin
//   duty_cnt   - high cycles of the last complete period (saturating)
//   period_cnt - rising-to-rising cycles of the last complete period, 0 when stuck
//   valid      - one-cycle strobe on each measurement update
//   stuck      - no input edge seen for the timeout window
// master: drives the pin and observes results; slave: the capture block.
interface pwm_capture_if #(
    parameter int unsigned PD_CNT = 8
);
    logic              pwm_in;
    logic [PD_CNT-1:0] duty_cnt;
    logic [PD_CNT:0]   period_cnt;
    logic              valid;
    logic              stuck;

    modport master (
        output pwm_in,
        input  duty_cnt,
        input  period_cnt,
        input  valid,
        input  stuck
    );

    modport slave (
        input  pwm_in,
        output duty_cnt,
        output period_cnt,
        output valid,
        output stuck
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an incoming PWM waveform.
// Ports:
//   clk - system clock
//   rst - synchronous, active-low reset
//   bus - pwm_capture_if.slave (pwm_in in; duty_cnt, period_cnt, valid, stuck out)
// The input goes through a 3-flop synchronizer; edges are detected between the
// 2nd and 3rd flops. A measurement is reported on each rise that closes a fully
// observed high+low period. With no edge for 2^(PD_CNT+1)-1 cycles the block
// reports a stuck level once and waits for activity.
module pwm_capture #(
    parameter int unsigned PD_CNT = 8
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    localparam logic [PD_CNT:0]   TMAX   = '1;
    localparam logic [PD_CNT-1:0] HI_MAX = '1;

    typedef enum logic [2:0] {
        SEARCH,
        ARMED,
        MEAS_HIGH,
        MEAS_LOW,
        STUCK
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [PD_CNT-1:0] hi_q, hi_d;
    logic [PD_CNT:0]   per_q, per_d;
    logic [PD_CNT-1:0] hi_lat_q, hi_lat_d;
    logic [PD_CNT-1:0] duty_q, duty_d;
    logic [PD_CNT:0]   period_q, period_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;

    logic              rise, fall, timeout;
    logic [PD_CNT-1:0] hi_inc;
    logic [PD_CNT:0]   per_inc;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    // An edge in the same cycle as the timeout takes precedence.
    assign timeout = (state_q != STUCK) && (per_q == TMAX) && !(rise || fall);
    assign hi_inc  = (hi_q == HI_MAX) ? hi_q : hi_q + 1'b1;
    assign per_inc = (per_q == TMAX) ? per_q : per_q + 1'b1;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= SEARCH;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            hi_q     <= '0;
            per_q    <= '0;
            hi_lat_q <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= bus.pwm_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            hi_q     <= hi_d;
            per_q    <= per_d;
            hi_lat_q <= hi_lat_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (fall)         state_d = ARMED;
                else if (timeout) state_d = STUCK;
            end
            ARMED: begin
                if (rise)         state_d = MEAS_HIGH;
                else if (timeout) state_d = STUCK;
            end
            MEAS_HIGH: begin
                if (fall)         state_d = MEAS_LOW;
                else if (timeout) state_d = STUCK;
            end
            MEAS_LOW: begin
                if (rise)         state_d = MEAS_HIGH;
                else if (timeout) state_d = STUCK;
            end
            STUCK: begin
                if (rise)         state_d = MEAS_HIGH;
                else if (fall)    state_d = ARMED;
            end
            default:              state_d = SEARCH;
        endcase
    end

    // Counter and output logic
    always_comb begin
        hi_d     = hi_q;
        per_d    = per_q;
        hi_lat_d = hi_lat_q;
        duty_d   = duty_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        unique case (state_q)
            SEARCH: begin
                per_d = per_inc;
                if (fall) begin
                    hi_d  = 1;
                    per_d = 1;
                end
            end
            ARMED: begin
                per_d = per_inc;
                if (rise) begin
                    hi_d  = 1;
                    per_d = 1;
                end
            end
            MEAS_HIGH: begin
                hi_d  = hi_inc;
                per_d = per_inc;
                if (fall) hi_lat_d = hi_q;
            end
            MEAS_LOW: begin
                per_d = per_inc;
                if (rise) begin
                    duty_d   = hi_lat_q;
                    period_d = per_q;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b0;
                    hi_d     = 1;
                    per_d    = 1;
                end
            end
            STUCK: begin
                if (rise || fall) begin
                    hi_d  = 1;
                    per_d = 1;
                end
            end
            default: ;
        endcase
        if (timeout) begin
            duty_d   = s2_q ? HI_MAX : '0;
            period_d = '0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
        end
    end

    assign bus.duty_cnt   = duty_q;
    assign bus.period_cnt = period_q;
    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture with PD_CNT=8.
// A PWM generator process drives pwm_in on the falling clock edge; a monitor
// counts valid strobes and back-to-back valid occurrences.
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;

    pwm_capture_if #(.PD_CNT(8)) bus ();

    pwm_capture #(.PD_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Generator configuration
    bit gen_mode  = 1'b0;  // 0: constant level, 1: waveform
    bit gen_level = 1'b0;
    int gen_hi    = 64;
    int gen_lo    = 192;
    int gen_phase = 0;

    int valid_cnt  = 0;
    int consec_cnt = 0;
    bit prev_valid = 1'b0;

    logic [7:0] cap_duty;
    logic [8:0] cap_period;
    logic       cap_stuck;

    initial begin
        bus.pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_mode) begin
                bus.pwm_in = (gen_phase < gen_hi);
                gen_phase  = (gen_phase + 1 >= gen_hi + gen_lo) ? 0 : gen_phase + 1;
            end else begin
                bus.pwm_in = gen_level;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid) begin
                if (prev_valid) consec_cnt++;
                valid_cnt++;
            end
            prev_valid = bus.valid;
        end
    end

    task automatic wait_valid(input int maxc, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                got        = 1'b1;
                cyc        = i;
                cap_duty   = bus.duty_cnt;
                cap_period = bus.period_cnt;
                cap_stuck  = bus.stuck;
                break;
            end
        end
    endtask

    task automatic set_wave(input int hi, input int lo);
        gen_hi    = hi;
        gen_lo    = lo;
        gen_phase = 0;
        gen_mode  = 1'b1;
    endtask

    task automatic set_const(input bit lvl);
        gen_level = lvl;
        gen_mode  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_const(1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (bus.duty_cnt !== 8'd0) $display("FAIL reset_duty got=%0d exp=0", bus.duty_cnt); else passed++;
        total++; if (bus.period_cnt !== 9'd0) $display("FAIL reset_period got=%0d exp=0", bus.period_cnt); else passed++;
        total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid); else passed++;
        total++; if (bus.stuck !== 1'b0) $display("FAIL reset_stuck got=%b exp=0", bus.stuck); else passed++;
    endtask

    task automatic test_const_low();
        bit got;
        int cyc;
        int base;
        set_const(1'b0);
        apply_reset();
        base = valid_cnt;
        repeat (500) @(negedge clk);
        total++; if (valid_cnt !== base) $display("FAIL low_early_valid got=%0d exp=%0d", valid_cnt, base); else passed++;
        wait_valid(40, got, cyc);
        total++; if (!got) $display("FAIL low_timeout_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd0) $display("FAIL low_duty got=%0d exp=0", cap_duty); else passed++;
        total++; if (cap_period !== 9'd0) $display("FAIL low_period got=%0d exp=0", cap_period); else passed++;
        total++; if (cap_stuck !== 1'b1) $display("FAIL low_stuck got=%b exp=1", cap_stuck); else passed++;
        repeat (600) @(negedge clk);
        total++; if (valid_cnt !== base + 1) $display("FAIL low_single_valid got=%0d exp=%0d", valid_cnt - base, 1); else passed++;
        total++; if (bus.stuck !== 1'b1) $display("FAIL low_stuck_hold got=%b exp=1", bus.stuck); else passed++;
        set_wave(10, 246);
        wait_valid(700, got, cyc);
        total++; if (!got) $display("FAIL recover_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd10) $display("FAIL recover_duty got=%0d exp=10", cap_duty); else passed++;
        total++; if (cap_period !== 9'd256) $display("FAIL recover_period got=%0d exp=256", cap_period); else passed++;
        total++; if (cap_stuck !== 1'b0) $display("FAIL recover_stuck got=%b exp=0", cap_stuck); else passed++;
    endtask

    task automatic test_const_high();
        bit got;
        int cyc;
        int base;
        set_const(1'b1);
        apply_reset();
        base = valid_cnt;
        repeat (490) @(negedge clk);
        total++; if (valid_cnt !== base) $display("FAIL high_early_valid got=%0d exp=%0d", valid_cnt, base); else passed++;
        wait_valid(40, got, cyc);
        total++; if (!got) $display("FAIL high_timeout_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd255) $display("FAIL high_duty got=%0d exp=255", cap_duty); else passed++;
        total++; if (cap_period !== 9'd0) $display("FAIL high_period got=%0d exp=0", cap_period); else passed++;
        total++; if (cap_stuck !== 1'b1) $display("FAIL high_stuck got=%b exp=1", cap_stuck); else passed++;
        repeat (300) @(negedge clk);
        total++; if (valid_cnt !== base + 1) $display("FAIL high_single_valid got=%0d exp=1", valid_cnt - base); else passed++;
    endtask

    task automatic test_duty64();
        bit got;
        int cyc;
        int base;
        rst = 1'b0;
        set_wave(64, 192);
        apply_reset();
        base = valid_cnt;
        repeat (400) @(negedge clk);
        total++; if (valid_cnt !== base) $display("FAIL d64_early_valid got=%0d exp=%0d", valid_cnt, base); else passed++;
        wait_valid(300, got, cyc);
        total++; if (!got) $display("FAIL d64_first_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd64) $display("FAIL d64_duty got=%0d exp=64", cap_duty); else passed++;
        total++; if (cap_period !== 9'd256) $display("FAIL d64_period got=%0d exp=256", cap_period); else passed++;
        total++; if (cap_stuck !== 1'b0) $display("FAIL d64_stuck got=%b exp=0", cap_stuck); else passed++;
        wait_valid(300, got, cyc);
        total++; if (cyc !== 256) $display("FAIL d64_interval got=%0d exp=256", cyc); else passed++;
        total++; if (cap_duty !== 8'd64) $display("FAIL d64_duty2 got=%0d exp=64", cap_duty); else passed++;
    endtask

    task automatic test_duty_change();
        bit got;
        int cyc;
        repeat (30) @(negedge clk);
        gen_hi = 200;
        gen_lo = 56;
        wait_valid(300, got, cyc);  // straddled frame, value not checked
        wait_valid(300, got, cyc);
        total++; if (!got) $display("FAIL chg_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd200) $display("FAIL chg_duty got=%0d exp=200", cap_duty); else passed++;
        total++; if (cap_period !== 9'd256) $display("FAIL chg_period got=%0d exp=256", cap_period); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit got;
        int cyc;
        int base;
        set_wave(64, 192);
        wait_valid(600, got, cyc);
        wait_valid(300, got, cyc);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (bus.duty_cnt !== 8'd0) $display("FAIL mid_rst_duty got=%0d exp=0", bus.duty_cnt); else passed++;
        total++; if (bus.period_cnt !== 9'd0) $display("FAIL mid_rst_period got=%0d exp=0", bus.period_cnt); else passed++;
        base = valid_cnt;
        repeat (400) @(negedge clk);
        total++; if (valid_cnt !== base) $display("FAIL mid_rst_early got=%0d exp=%0d", valid_cnt, base); else passed++;
        wait_valid(200, got, cyc);
        total++; if (!got) $display("FAIL mid_rst_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd64) $display("FAIL mid_rst_duty2 got=%0d exp=64", cap_duty); else passed++;
        total++; if (cap_period !== 9'd256) $display("FAIL mid_rst_period2 got=%0d exp=256", cap_period); else passed++;
    endtask

    task automatic test_custom();
        bit got;
        int cyc;
        rst = 1'b0;
        set_wave(300, 100);
        apply_reset();
        wait_valid(1500, got, cyc);
        total++; if (!got) $display("FAIL sat_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd255) $display("FAIL sat_duty got=%0d exp=255", cap_duty); else passed++;
        total++; if (cap_period !== 9'd400) $display("FAIL sat_period got=%0d exp=400", cap_period); else passed++;
        rst = 1'b0;
        set_wave(1, 5);
        apply_reset();
        wait_valid(100, got, cyc);
        total++; if (!got) $display("FAIL narrow_valid got=none exp=valid"); else passed++;
        total++; if (cap_duty !== 8'd1) $display("FAIL narrow_duty got=%0d exp=1", cap_duty); else passed++;
        total++; if (cap_period !== 9'd6) $display("FAIL narrow_period got=%0d exp=6", cap_period); else passed++;
        wait_valid(20, got, cyc);
        total++; if (cyc !== 6) $display("FAIL narrow_interval got=%0d exp=6", cyc); else passed++;
    endtask

    task automatic test_back_to_back();
        total++; if (consec_cnt !== 0) $display("FAIL valid_consecutive got=%0d exp=0", consec_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_const_low();
        test_const_high();
        test_duty64();
        test_duty_change();
        test_reset_midframe();
        test_custom();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side companion of the team's counter-based PWM generator: it recovers `duty_cnt` and the frame length from a PWM pin driven by another board or a loopback. It sits behind an I/O pin, synchronizes the input, and presents registered measurements with a one-cycle `valid` strobe per completed period.

## Interface
Parameters:
- PD_CNT, 8: duty counter width. Matches the generator; `period_cnt` is PD_CNT+1 bits so a full 2^PD_CNT frame fits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- pwm_in  input  1  asynchronous PWM input
- duty_cnt  output  PD_CNT  high cycles of the last complete period, saturating at 2^PD_CNT-1
- period_cnt  output  PD_CNT+1  rising-to-rising cycles of the last complete period; 0 when stuck
- valid  output  1  one-cycle strobe on each `duty_cnt`/`period_cnt` update
- stuck  output  1  input has shown no edge for TMAX = 2^(PD_CNT+1)-1 cycles

## Operation
- Synchronizer: s1 <- pwm_in, s2 <- s1, s3 <- s2. All three reset to 1.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Reset value of 1 means a high input at reset release produces no rise. A low input produces only a harmless fall.
- Counters:
  - hi_ctr: PD_CNT bits, saturates at all-ones.
  - per_ctr: PD_CNT+1 bits, saturates at TMAX.
  - Both reset to 0.
  - "Restart" loads both with 1.
- States (reset: SEARCH):
  - SEARCH: per_ctr++. On fall: restart, go to ARMED. Discards any partial high pulse.
  - ARMED: per_ctr++. On rise: restart, go to MEAS_HIGH. No report.
  - MEAS_HIGH: hi_ctr++ and per_ctr++. On fall: latch hi_lat <= hi_ctr, per_ctr++, go to MEAS_LOW.
  - MEAS_LOW: per_ctr++. On rise: report (duty_cnt <= hi_lat, period_cnt <= per_ctr, valid <= 1, stuck <= 0), restart, go to MEAS_HIGH.
  - STUCK: counters hold. On rise: restart, go to MEAS_HIGH. On fall: restart, go to ARMED. `stuck` stays 1 until the next report.
- Timeout (any state except STUCK): per_ctr == TMAX and no edge this cycle → go to STUCK.
  - Outputs on entry: duty_cnt <= s2 ? all-ones : 0; period_cnt <= 0; stuck <= 1; valid <= 1 (exactly once per entry).
- Simultaneous edge and timeout: the edge wins.
- hi_ctr saturation: a high time ≥ 2^PD_CNT reports duty_cnt = 2^PD_CNT-1. The period is still reported exactly if ≤ TMAX.
- Reset held: all outputs 0, state SEARCH, counters 0, sync regs 1. Any measurement in progress is discarded.

## Timing
- Output reset values: duty_cnt 0, period_cnt 0, valid 0, stuck 0.
- Latency: edge E0 is the first edge sampling a new pwm_in level.
  - E1: rise/fall visible.
  - E2: outputs registered. `valid` is high for the cycle after E2.
- Measurement is exact in cycles: a generator with duty D and period 2^PD_CNT reports duty_cnt = D and period_cnt = 2^PD_CNT.
- Minimum resolvable pulse: 1 cycle high or low, as seen at s2. Shorter asynchronous glitches may be missed.
- First report after reset or SEARCH: needs one fall, one rise, one fall, then one rise, i.e. at least one complete period after arming.
- `valid` never asserts on two consecutive cycles.

## Test plan
- PD_CNT=8, generator duty 64 looped to pwm_in → valid every 256 cycles; duty_cnt=64, period_cnt=256, stuck=0. No valid before the second observed rise.
- Duty changes 64→200 mid-frame → the next complete frame reports 200/256; no report mixes old and new frames except the straddled one.
- pwm_in constant 0 from reset → single valid pulse 511 cycles after the initial fall; duty_cnt=0, period_cnt=0, stuck=1; no further valid. A later duty-10 input clears stuck with the first report of 10/256.
- pwm_in constant 1 from reset → no spurious rise; after 511 cycles a single valid with duty_cnt=255, period_cnt=0, stuck=1.
- Custom waveform: 300 high / 100 low → duty_cnt=255 (saturated), period_cnt=400. A 1-high / 5-low waveform → duty_cnt=1, period_cnt=6.
- rst driven low for 1 cycle during MEAS_HIGH of a duty-64 stream → outputs 0 on the next cycle. The first report after release comes only after a full re-armed frame and equals 64/256.
